wr_drain: RTL and testbench
===========================

WR_DRAIN -- requirements
Module: wr_drain

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of a write entry and of the memory bus address.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 fifo_empty  input  1  write fifo holds no entries.
REQ-005 fifo_rd_data  input  98  head entry: [97:34] store data (byte 0 in [41:34]), [33:2] byte address, [1:0] size code.
REQ-006 fifo_rd  output  1  pop request to write fifo, one cycle per entry.
REQ-007 mem_wr_req  output  1  memory write request, held until acknowledged.
REQ-008 mem_wr_addr  output  ADDR_W  8-byte-aligned line address; bits [2:0] always 0.
REQ-009 mem_wr_data  output  64  line-positioned write data.
REQ-010 mem_wr_be  output  8  byte enables, bit i qualifies mem_wr_data[8i+7:8i].
REQ-011 mem_wr_ack  input  1  memory accepted current request.
REQ-012 wr_idle  output  1  high when no entry is held and fifo_empty is high; used by the pipeline for store/load ordering.

Function
REQ-013 Size code SHALL map 00=1, 01=2, 10=4, 11=8 bytes; only the low N bytes of the data field are written.
REQ-014 States SHALL be IDLE, BEAT0, BEAT1.
REQ-015 IDLE: if fifo_empty low, fifo_rd SHALL be high for that cycle, the entry SHALL be captured at the same edge, and next state SHALL be BEAT0; otherwise fifo_rd low, stay IDLE.
REQ-016 fifo_rd SHALL never be high outside IDLE or while fifo_empty is high.
REQ-017 Offset off = addr[2:0]; 16-bit mask = ((1<<N)-1)<<off; 128-bit data = data<<(8*off); crossing = off+N > 8.
REQ-018 BEAT0 SHALL drive mem_wr_req=1, mem_wr_addr={addr[ADDR_W-1:3],3'b0}, mem_wr_data=low 64 shifted bits, mem_wr_be=mask[7:0].
REQ-019 BEAT1 SHALL drive mem_wr_req=1, mem_wr_addr=line address+8 (modulo 2^ADDR_W, wraps to 0), mem_wr_data=high 64 shifted bits, mem_wr_be=mask[15:8].
REQ-020 Request outputs SHALL remain stable while mem_wr_req is high and mem_wr_ack is low.
REQ-021 On mem_wr_ack in BEAT0: next state BEAT1 if crossing, else IDLE; in BEAT1: next state IDLE.
REQ-022 mem_wr_ack in IDLE SHALL be ignored.
REQ-023 Latency: pop-to-first-request 1 cycle; one idle cycle SHALL separate consecutive entries (ack edge -> IDLE -> pop).
REQ-024 Outside BEAT0/BEAT1, mem_wr_req, mem_wr_be SHALL be 0; mem_wr_addr, mem_wr_data don't-care but SHALL be 0 after reset.
REQ-025 wr_idle SHALL be high exactly when state is IDLE and fifo_empty is high.
REQ-026 Entries SHALL be written to memory in pop order; no merging or reordering.

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE and clear the captured entry; all outputs 0 except wr_idle = fifo_empty.
REQ-028 Reset during BEAT0/BEAT1 SHALL abandon the entry; mem_wr_req SHALL be 0 from the cycle after the reset edge.

Structure
REQ-029 Shared package SHALL hold size-code encodings, entry field offsets (data/addr/size), entry width 98, and state encodings.
REQ-030 One combinational sub-module wr_align SHALL compute shifted 128-bit data, 16-bit mask and crossing flag from data, addr[2:0], size.
REQ-031 Captured entry, state and output registers SHALL use the team register cell with load enable.

Verification
REQ-032 Aligned 8-byte: addr 0x100, data 0x1122334455667788, ack after 2 cycles -> one request, addr 0x100, be 0xFF, data unchanged, back to IDLE.
REQ-033 Byte store: addr 0x205, size 00, data low byte 0xAB -> addr 0x200, be 0x20, data[47:40]=0xAB, single beat.
REQ-034 Crossing: addr 0x306, size 10, data 0xDEADBEEF -> beat0 addr 0x300 be 0xC0 data[63:48]=0xBEEF; beat1 addr 0x308 be 0x03 data[15:0]=0xDEAD.
REQ-035 Wrap: addr 0xFFFFFFFC, size 11 -> beat0 addr 0xFFFFFFF8 be 0xF0; beat1 addr 0x00000000 be 0x0F.
REQ-036 Back-to-back: three entries queued, ack held high -> fifo_rd pulses spaced by one IDLE cycle, order preserved, fifo_rd never high while fifo_empty high.
REQ-037 Reset in BEAT0 with ack low -> next cycle IDLE, mem_wr_req 0, stray ack then ignored.

Source files
------------

// File: rtl/wr_drain_pkg.sv
// Shared definitions for the store-drain path: write-fifo entry layout,
// size-code encodings and drain FSM state encodings.
package wr_drain_pkg;

  localparam int ENTRY_W  = 98;
  localparam int DATA_MSB = 97;
  localparam int DATA_LSB = 34;
  localparam int ADDR_MSB = 33;
  localparam int ADDR_LSB = 2;
  localparam int SIZE_MSB = 1;
  localparam int SIZE_LSB = 0;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  // Unshifted byte-enable pattern covering the low N bytes of the store data.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_BYTE:  m = 8'h01;
      SZ_HALF:  m = 8'h03;
      SZ_WORD:  m = 8'h0F;
      SZ_DWORD: m = 8'hFF;
      default:  m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/reg_en.sv
// Register cell with load enable and synchronous active-low clear to zero.
module reg_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wr_align.sv
// Positions a store within a 16-byte window starting at its 8-byte line:
// shifted data, byte mask and a flag for spilling into the next line.
module wr_align
  import wr_drain_pkg::*;
(
  input  logic [63:0]  data,
  input  logic [2:0]   off,
  input  logic [1:0]   size,
  output logic [127:0] shifted,
  output logic [15:0]  mask,
  output logic         crossing
);

  logic [4:0] nbytes;

  always_comb begin
    nbytes   = 5'd1 << size;
    shifted  = {64'd0, data} << {off, 3'b000};
    mask     = {8'd0, size_mask(size)} << off;
    crossing = ({2'b00, off} + nbytes) > 5'd8;
  end

endmodule

// File: rtl/wr_drain.sv
// Drains the store fifo to memory one entry at a time, splitting stores
// that straddle an 8-byte line into two line-aligned write beats.
//
// state    | meaning
// ST_IDLE  | no entry held; pops the fifo head when one is present
// ST_BEAT0 | first (or only) line write outstanding
// ST_BEAT1 | second line write of a crossing store outstanding
module wr_drain
  import wr_drain_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  input  logic [ENTRY_W-1:0] fifo_rd_data,
  output logic               fifo_rd,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [63:0]        mem_wr_data,
  output logic [7:0]         mem_wr_be,
  input  logic               mem_wr_ack,
  output logic               wr_idle
);

  logic [1:0]        state_d, state_q;
  logic [63:0]       hi_data_d, hi_data_q;
  logic [7:0]        hi_be_d, hi_be_q;
  logic              cross_d, cross_q;
  logic              req_d, req_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [63:0]       data_d, data_q;
  logic [7:0]        be_d, be_q;
  logic              pop;
  logic [ADDR_W-1:0] in_addr;
  logic [127:0]      al_shifted;
  logic [15:0]       al_mask;
  logic              al_cross;

  assign in_addr = ADDR_W'(fifo_rd_data[ADDR_MSB:ADDR_LSB]);

  wr_align u_align (
    .data     (fifo_rd_data[DATA_MSB:DATA_LSB]),
    .off      (fifo_rd_data[ADDR_LSB+2:ADDR_LSB]),
    .size     (fifo_rd_data[SIZE_MSB:SIZE_LSB]),
    .shifted  (al_shifted),
    .mask     (al_mask),
    .crossing (al_cross)
  );

  // Only the second-beat half of the entry needs holding; beat 0 goes
  // straight into the output registers at the pop edge.
  assign hi_data_d = al_shifted[127:64];
  assign hi_be_d   = al_mask[15:8];
  assign cross_d   = al_cross;

  always_comb begin
    pop     = (state_q == ST_IDLE) && !fifo_empty;
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_BEAT0;
          req_d   = 1'b1;
          addr_d  = in_addr & ~ADDR_W'(7);
          data_d  = al_shifted[63:0];
          be_d    = al_mask[7:0];
        end
      end
      ST_BEAT0: begin
        if (mem_wr_ack) begin
          if (cross_q) begin
            state_d = ST_BEAT1;
            addr_d  = addr_q + ADDR_W'(8);
            data_d  = hi_data_q;
            be_d    = hi_be_q;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            be_d    = 8'd0;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_wr_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          be_d    = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        be_d    = 8'd0;
      end
    endcase
  end

  reg_en #(.W(2))      u_state   (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d),   .q(state_q));
  reg_en #(.W(64))     u_hi_data (.clk(clk), .rst_n(rst_n), .en(pop),  .d(hi_data_d), .q(hi_data_q));
  reg_en #(.W(8))      u_hi_be   (.clk(clk), .rst_n(rst_n), .en(pop),  .d(hi_be_d),   .q(hi_be_q));
  reg_en #(.W(1))      u_cross   (.clk(clk), .rst_n(rst_n), .en(pop),  .d(cross_d),   .q(cross_q));
  reg_en #(.W(1))      u_req     (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(req_d),     .q(req_q));
  reg_en #(.W(ADDR_W)) u_addr    (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(addr_d),    .q(addr_q));
  reg_en #(.W(64))     u_data    (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(data_d),    .q(data_q));
  reg_en #(.W(8))      u_be      (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(be_d),      .q(be_q));

  assign fifo_rd     = pop;
  assign mem_wr_req  = req_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign mem_wr_be   = be_q;
  assign wr_idle     = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_wr_drain.sv
// Randomized bench for wr_drain: a queue acts as the write fifo and a
// transaction-level model predicts the memory beats of every popped store.
module tb_wr_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [97:0] fifo_rd_data;
  logic        fifo_rd;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_be;
  logic        mem_wr_ack;
  logic        wr_idle;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  logic [97:0] fifo_q[$];
  beat_t       exp_q[$];
  int          held_beats = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_mode = 3;
  int          req_run = 0;
  int          rand_left = 0;
  bit          chk_en = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  logic [7:0]  prev_be;

  always #5 clk = ~clk;

  wr_drain #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_be    (mem_wr_be),
    .mem_wr_ack   (mem_wr_ack),
    .wr_idle      (wr_idle)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [97:0] mk_entry(input logic [63:0] d, input logic [31:0] a,
                                           input logic [1:0] sz);
    return {d, a, sz};
  endfunction

  function automatic logic [97:0] rand_entry();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_FFF8;
    return mk_entry({$urandom, $urandom}, a, 2'($urandom_range(0, 3)));
  endfunction

  // Expected beats of one store: bytes off..off+n-1 of a 16-byte window
  // starting at the store's 8-byte line.
  function automatic void model_push(input logic [97:0] e);
    logic [63:0]  d = e[97:34];
    logic [31:0]  a = e[33:2];
    int           n = 1 << e[1:0];
    int           off = int'(a[2:0]);
    logic [127:0] sh;
    logic [15:0]  m;
    logic [31:0]  line;
    beat_t        b;
    sh   = {64'd0, d} << (8 * off);
    m    = '0;
    line = a - 32'(off);
    for (int i = 0; i < 16; i++) if (i >= off && i < off + n) m[i] = 1'b1;
    b.addr = line; b.data = sh[63:0]; b.be = m[7:0];
    exp_q.push_back(b);
    held_beats = 1;
    if (off + n > 8) begin
      b.addr = line + 32'd8; b.data = sh[127:64]; b.be = m[15:8];
      exp_q.push_back(b);
      held_beats = 2;
    end
  endfunction

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic cycle();
    bit    pop_s;
    bit    hs;
    beat_t b;
    @(negedge clk);
    if (chk_en) begin
      check("fifo_rd", 128'(fifo_rd), 128'(held_beats == 0 && fifo_q.size() != 0));
      check("wr_idle", 128'(wr_idle), 128'(held_beats == 0 && fifo_q.size() == 0));
      check("mem_wr_req", 128'(mem_wr_req), 128'(held_beats != 0));
      if (held_beats == 0) check("be_idle", 128'(mem_wr_be), 128'd0);
      if (prev_hold) begin
        check("hold_addr", 128'(mem_wr_addr), 128'(prev_addr));
        check("hold_data", 128'(mem_wr_data), 128'(prev_data));
        check("hold_be", 128'(mem_wr_be), 128'(prev_be));
      end
    end
    case (ack_mode)
      0:       mem_wr_ack = ($urandom_range(0, 2) == 0);
      1:       mem_wr_ack = 1'b1;
      2:       mem_wr_ack = mem_wr_req && (req_run >= 2);
      default: mem_wr_ack = 1'b0;
    endcase
    req_run = (mem_wr_req === 1'b1 && !mem_wr_ack) ? req_run + 1 : 0;
    hs      = chk_en && rst_n && (mem_wr_req === 1'b1) && mem_wr_ack;
    pop_s   = (fifo_rd === 1'b1);
    if (hs) begin
      if (exp_q.size() == 0) check("beat_expected", 128'd0, 128'd1);
      else begin
        b = exp_q.pop_front();
        check("beat_addr", 128'(mem_wr_addr), 128'(b.addr));
        check("beat_data", 128'(mem_wr_data), 128'(b.data));
        check("beat_be", 128'(mem_wr_be), 128'(b.be));
      end
    end
    prev_hold = (mem_wr_req === 1'b1) && !mem_wr_ack;
    prev_addr = mem_wr_addr;
    prev_data = mem_wr_data;
    prev_be   = mem_wr_be;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      held_beats = 0;
      exp_q.delete();
      prev_hold = 1'b0;
      req_run   = 0;
    end else begin
      if (hs && held_beats > 0) held_beats--;
      if (pop_s && fifo_q.size() != 0) model_push(fifo_q.pop_front());
    end
    if (rand_left > 0 && $urandom_range(0, 2) == 0) begin
      fifo_q.push_back(rand_entry());
      rand_left--;
    end
    drive_fifo();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((fifo_q.size() != 0 || held_beats != 0 || rand_left != 0) && n < limit) begin
      cycle();
      n++;
    end
    check({tag, "_drained"},
          128'(fifo_q.size() == 0 && held_beats == 0 && rand_left == 0 && exp_q.size() == 0),
          128'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req"}, 128'(mem_wr_req), 128'd0);
    check({tag, "_addr"}, 128'(mem_wr_addr), 128'd0);
    check({tag, "_data"}, 128'(mem_wr_data), 128'd0);
    check({tag, "_be"}, 128'(mem_wr_be), 128'd0);
    check({tag, "_wr_idle"}, 128'(wr_idle), 128'(fifo_empty));
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    mem_wr_ack = 1'b0;
    drive_fifo();
    repeat (3) cycle();
    rst_n = 1'b1;
    check_reset_outs("reset");
    check("reset_fifo_rd", 128'(fifo_rd), 128'd0);
    chk_en = 1'b1;

    // Directed stores: aligned dword, byte at offset 5, crossing word, wrapping dword.
    ack_mode = 2;
    fifo_q.push_back(mk_entry(64'h1122_3344_5566_7788, 32'h0000_0100, 2'b11));
    fifo_q.push_back(mk_entry({$urandom, $urandom} & ~64'hFF | 64'hAB, 32'h0000_0205, 2'b00));
    fifo_q.push_back(mk_entry({32'($urandom), 32'hDEAD_BEEF}, 32'h0000_0306, 2'b10));
    fifo_q.push_back(mk_entry({$urandom, $urandom}, 32'hFFFF_FFFC, 2'b11));
    drive_fifo();
    drain("directed", 200);

    // Back-to-back with ack held high.
    ack_mode = 1;
    repeat (3) fifo_q.push_back(rand_entry());
    drive_fifo();
    drain("b2b", 100);

    ack_mode  = 0;
    rand_left = 300;
    drain("random", 20000);

    // Reset while beat 0 is waiting for an ack, then a stray ack.
    ack_mode = 3;
    fifo_q.push_back(mk_entry({$urandom, $urandom}, 32'h0000_0400, 2'b11));
    drive_fifo();
    n = 0;
    while (mem_wr_req !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    check("beat0_reached", 128'(mem_wr_req), 128'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_reset_outs("abandon");
    ack_mode = 1;
    repeat (4) cycle();
    ack_mode = 0;
    fifo_q.push_back(rand_entry());
    drive_fifo();
    drain("recover", 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
